// File: rtl/reset_release_sequencer_pkg.sv
// Shared definitions for the reset release sequencer: FSM state encodings
// and default parameter values.
package reset_release_sequencer_pkg;

  typedef enum logic [1:0] {
    RS_GAP   = 2'd0,
    RS_WAIT  = 2'd1,
    RS_DONE  = 2'd2,
    RS_FAULT = 2'd3
  } rs_state_e;

  localparam int DEF_STAGES     = 4;
  localparam int DEF_STAGE_BITS = 2;
  localparam int DEF_GAP_CYCLES = 16;
  localparam int DEF_TIMEOUT    = 1024;
  localparam int DEF_CNT_BITS   = 10;

endpackage

// File: rtl/reset_release_sequencer_cycle_counter.sv
// Free-running phase counter with synchronous clear and enable; flags when
// the count equals the terminal value chosen by the caller.
module reset_release_sequencer_cycle_counter #(
  parameter int CNT_BITS = 10
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                enable,
  input  logic [CNT_BITS-1:0] terminal,
  output logic [CNT_BITS-1:0] count,
  output logic                at_terminal
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_BITS'(1);
    end else begin
      count <= count;
    end
  end

  assign at_terminal = (count == terminal);

endmodule

// File: rtl/reset_release_sequencer.sv
// Releases per-subsystem resets one at a time, waiting for each stage's ready
// acknowledge; a timeout or a later ready drop forces everything back into reset.
module reset_release_sequencer
  import reset_release_sequencer_pkg::*;
#(
  parameter int STAGES     = DEF_STAGES,
  parameter int STAGE_BITS = DEF_STAGE_BITS,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_BITS   = DEF_CNT_BITS
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [STAGES-1:0]     Ready,
  output logic [STAGES-1:0]     StageReset,
  output logic                  AllReady,
  output logic                  Fault,
  output logic [STAGE_BITS-1:0] FaultStage
);

  localparam logic [CNT_BITS-1:0]   GAP_TERM     = CNT_BITS'(GAP_CYCLES - 1);
  localparam logic [CNT_BITS-1:0]   TIMEOUT_TERM = CNT_BITS'(TIMEOUT - 1);
  localparam logic [STAGE_BITS-1:0] LAST_IDX     = STAGE_BITS'(STAGES - 1);

  rs_state_e             state;
  logic [STAGE_BITS-1:0] idx;
  logic [CNT_BITS-1:0]   count;
  logic [CNT_BITS-1:0]   term;
  logic                  at_term;
  logic                  cnt_clear;
  logic                  cnt_en;
  logic                  ready_cur;
  logic                  drop_any;
  logic [STAGE_BITS-1:0] drop_idx;

  // One counter serves both phases; it restarts whenever a phase ends.
  always_comb begin
    ready_cur = Ready[idx];
    term      = (state == RS_GAP) ? GAP_TERM : TIMEOUT_TERM;
    cnt_en    = (state == RS_GAP) || (state == RS_WAIT);
    cnt_clear = Reset || !cnt_en || at_term || ((state == RS_WAIT) && ready_cur);
    drop_any  = 1'b0;
    drop_idx  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (!Ready[i]) begin
        drop_any = 1'b1;
        drop_idx = STAGE_BITS'(i);
      end
    end
  end

  reset_release_sequencer_cycle_counter #(
    .CNT_BITS (CNT_BITS)
  ) u_counter (
    .clk         (Clk),
    .clear       (cnt_clear),
    .enable      (cnt_en),
    .terminal    (term),
    .count       (count),
    .at_terminal (at_term)
  );

  // Sequencing FSM with registered outputs; Ready wins over a same-cycle timeout.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= RS_GAP;
      idx        <= '0;
      StageReset <= {STAGES{1'b1}};
      AllReady   <= 1'b0;
      Fault      <= 1'b0;
      FaultStage <= '0;
    end else begin
      case (state)
        RS_GAP: begin
          if (at_term) begin
            StageReset[idx] <= 1'b0;
            state           <= RS_WAIT;
          end
        end
        RS_WAIT: begin
          if (ready_cur) begin
            if (idx == LAST_IDX) begin
              state    <= RS_DONE;
              AllReady <= 1'b1;
            end else begin
              idx   <= idx + STAGE_BITS'(1);
              state <= RS_GAP;
            end
          end else if (at_term) begin
            state      <= RS_FAULT;
            StageReset <= {STAGES{1'b1}};
            AllReady   <= 1'b0;
            Fault      <= 1'b1;
            FaultStage <= idx;
          end
        end
        RS_DONE: begin
          if (drop_any) begin
            state      <= RS_FAULT;
            StageReset <= {STAGES{1'b1}};
            AllReady   <= 1'b0;
            Fault      <= 1'b1;
            FaultStage <= drop_idx;
          end
        end
        RS_FAULT: begin
          state <= RS_FAULT;
        end
        default: begin
          state      <= RS_FAULT;
          StageReset <= {STAGES{1'b1}};
          AllReady   <= 1'b0;
          Fault      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Self-checking bench for reset_release_sequencer: vector table, directed
// multi-cycle corner cases and randomized traffic against a timing model.
module tb_reset_release_sequencer;

  localparam int STAGES  = 4;
  localparam int GAP     = 16;
  localparam int TIMEOUT = 1024;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] Ready;
  logic [3:0] StageReset;
  logic       AllReady;
  logic       Fault;
  logic [1:0] FaultStage;

  always #5 Clk = ~Clk;

  reset_release_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Ready      (Ready),
    .StageReset (StageReset),
    .AllReady   (AllReady),
    .Fault      (Fault),
    .FaultStage (FaultStage)
  );

  int checks = 0;
  int errors = 0;

  // Model: time since reset release, release/ack bookkeeping by elapsed edges.
  int         since;
  int         mark;
  int         m_idx;
  bit         m_wait;
  logic [3:0] m_sr;
  logic       m_all;
  logic       m_fault;
  logic [1:0] m_fs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at since=%0d: got %0h expected %0h", name, since, act, exp);
    end
  endtask

  task automatic model_fault(input int stage);
    m_sr    = 4'b1111;
    m_all   = 1'b0;
    m_fault = 1'b1;
    m_fs    = 2'(stage);
  endtask

  task automatic model_update(input logic rst, input logic [3:0] rdy);
    if (rst) begin
      since = 0; mark = 0; m_idx = 0; m_wait = 1'b0;
      m_sr = 4'b1111; m_all = 1'b0; m_fault = 1'b0; m_fs = 2'd0;
      return;
    end
    since++;
    if (m_fault) return;
    if (m_all) begin
      for (int i = 0; i < STAGES; i++) begin
        if (!rdy[i]) begin
          model_fault(i);
          return;
        end
      end
    end else if (m_wait) begin
      if (rdy[m_idx]) begin
        if (m_idx == STAGES - 1) m_all = 1'b1;
        else begin
          m_idx++; m_wait = 1'b0; mark = since;
        end
      end else if (since - mark == TIMEOUT) begin
        model_fault(m_idx);
      end
    end else if (since - mark == GAP) begin
      m_sr[m_idx] = 1'b0;
      m_wait = 1'b1;
      mark = since;
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] rdy);
    Reset = rst;
    Ready = rdy;
    @(posedge Clk);
    model_update(rst, rdy);
    #1;
    check("model_sr",    32'(StageReset), 32'(m_sr));
    check("model_all",   32'(AllReady),   32'(m_all));
    check("model_fault", 32'(Fault),      32'(m_fault));
    check("model_fs",    32'(FaultStage), 32'(m_fs));
  endtask

  task automatic run(input int n, input logic [3:0] rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] rdy;
    int         cycles;
    logic [3:0] exp_sr;
    logic       exp_all;
    logic       exp_fault;
    logic [1:0] exp_fs;
  } vec_t;

  vec_t vecs[11];

  initial begin
    Reset = 1'b1;
    Ready = 4'b0000;

    vecs[0]  = '{1'b1, 4'b1111, 5,  4'b1111, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 4'b1111, 15, 4'b1111, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 4'b1111, 1,  4'b1110, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 4'b1111, 17, 4'b1100, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 4'b1111, 17, 4'b1000, 1'b0, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 4'b1111, 17, 4'b0000, 1'b0, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 4'b1111, 1,  4'b0000, 1'b1, 1'b0, 2'd0};
    vecs[7]  = '{1'b0, 4'b0011, 1,  4'b1111, 1'b0, 1'b1, 2'd2};
    vecs[8]  = '{1'b0, 4'b1111, 3,  4'b1111, 1'b0, 1'b1, 2'd2};
    vecs[9]  = '{1'b0, 4'b0000, 2,  4'b1111, 1'b0, 1'b1, 2'd2};
    vecs[10] = '{1'b1, 4'b0000, 1,  4'b1111, 1'b0, 1'b0, 2'd0};

    for (int v = 0; v < 11; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) step(vecs[v].rst, vecs[v].rdy);
      check($sformatf("vec%0d_sr", v),    32'(StageReset), 32'(vecs[v].exp_sr));
      check($sformatf("vec%0d_all", v),   32'(AllReady),   32'(vecs[v].exp_all));
      check($sformatf("vec%0d_fault", v), 32'(Fault),      32'(vecs[v].exp_fault));
      check($sformatf("vec%0d_fs", v),    32'(FaultStage), 32'(vecs[v].exp_fs));
    end

    // Stage 1 never acknowledges: fault at edge 1057.
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1111);
    run(1056, 4'b1101);
    check("to_nofault_1056", 32'(Fault), 32'd0);
    check("to_sr_1056", 32'(StageReset), 32'h8 | 32'h4);
    run(1, 4'b1101);
    check("to_fault", 32'(Fault), 32'd1);
    check("to_fs", 32'(FaultStage), 32'd1);
    check("to_sr", 32'(StageReset), 32'hf);
    check("to_all", 32'(AllReady), 32'd0);

    // Ready arrives on the timeout edge: no fault, stage 2 released 16 edges on.
    step(1'b1, 4'b1111);
    run(1056, 4'b1101);
    run(1, 4'b1111);
    check("race_nofault", 32'(Fault), 32'd0);
    check("race_sr", 32'(StageReset), 32'hc);
    run(15, 4'b1111);
    check("race_sr2_held", 32'(StageReset[2]), 32'd1);
    run(1, 4'b1111);
    check("race_sr2_rel", 32'(StageReset[2]), 32'd0);

    // Reset pulse while waiting on stage 2, then a clean full sequence.
    step(1'b1, 4'b1111);
    run(55, 4'b1011);
    check("mid_sr_wait2", 32'(StageReset), 32'h8);
    step(1'b1, 4'b1011);
    check("mid_sr_reset", 32'(StageReset), 32'hf);
    run(15, 4'b1111);
    check("mid_sr_15", 32'(StageReset), 32'hf);
    run(1, 4'b1111);
    check("mid_sr_16", 32'(StageReset), 32'he);
    run(51, 4'b1111);
    check("mid_sr_67", 32'(StageReset), 32'h0);
    check("mid_all_67", 32'(AllReady), 32'd0);
    run(1, 4'b1111);
    check("mid_all_68", 32'(AllReady), 32'd1);

    // Randomized traffic, occasional resets, varying ready density.
    for (int seg = 0; seg < 16; seg++) begin
      int p;
      case (seg % 4)
        0: p = 100;
        1: p = 97;
        2: p = 60;
        default: p = 99;
      endcase
      for (int c = 0; c < 200; c++) begin
        logic [3:0] r;
        for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 99) < p);
        step(($urandom_range(0, 299) == 0), r);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
